// File: rtl/iq_abs_avg.sv
// iq_abs_avg: windowed (|I|+|Q|)/2 magnitude average with decimated valid pulses; optional IQ_RSSI_PEAK_HOLD_EN adds iq_rssi_peak
module iq_abs_avg #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int WINDOW_LOG2   = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [IQ_DATA_WIDTH-1:0] ddc_i,
    input  logic [IQ_DATA_WIDTH-1:0] ddc_q,
    input  logic                     iq_valid,
    input  logic                     avg_clear,
`ifdef IQ_RSSI_PEAK_HOLD_EN
    output logic [IQ_DATA_WIDTH-1:0] iq_rssi_peak,
`endif
    output logic [IQ_DATA_WIDTH-1:0] iq_rssi,
    output logic                     iq_rssi_valid
);
    localparam int W = IQ_DATA_WIDTH;
    localparam int L = WINDOW_LOG2;
    localparam int N = 1 << L;
    localparam int M = W - 1;
    localparam int S = M + L;
    typedef logic [M-1:0] mag_t;

    // saturating absolute value: the most negative code maps to the largest positive one
    function automatic mag_t sabs(input logic [W-1:0] x);
        return x[W-1] ? ((x == {1'b1, {M{1'b0}}}) ? {M{1'b1}} : mag_t'(-x)) : x[M-1:0];
    endfunction

    logic [1:0]   rs;
    logic         rst_n_i;
    logic [L:0]   fill;
    logic [2:0]   dec;
    logic         tag;
    logic         v1, v2, v3, t1, t2, t3;
    mag_t         ai, aq, mag;
    mag_t         win [N];
    logic [L-1:0] ptr;
    logic [S-1:0] sum;
    logic [W-1:0] rssi_new;

    assign rst_n_i  = rs[1];
    assign tag      = (&dec) && (fill >= (L+1)'(N - 1));
    assign rssi_new = W'(sum >> L);

    // reset asserts immediately, releases two clk edges after rstn rises
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rs <= 2'b00;
        else       rs <= {rs[0], 1'b1};

    // fill and decimation counters advance per accepted sample
    always_ff @(posedge clk or negedge rst_n_i)
        if (!rst_n_i) begin
            fill <= '0;
            dec  <= '0;
        end else if (avg_clear) begin
            fill <= '0;
            dec  <= '0;
        end else if (iq_valid) begin
            fill <= (fill == (L+1)'(N)) ? fill : fill + 1'b1;
            dec  <= dec + 1'b1;
        end

    // stages 1 and 2: absolute values, then halved magnitude sum; tag marks a warm decimation wrap
    always_ff @(posedge clk or negedge rst_n_i)
        if (!rst_n_i) begin
            {v1, t1, v2, t2} <= '0;
            ai  <= '0;
            aq  <= '0;
            mag <= '0;
        end else if (avg_clear) begin
            {v1, v2} <= '0;
        end else begin
            v1 <= iq_valid;
            v2 <= v1;
            if (iq_valid) begin
                ai <= sabs(ddc_i);
                aq <= sabs(ddc_q);
                t1 <= tag;
            end
            if (v1) begin
                mag <= mag_t'(({1'b0, ai} + {1'b0, aq}) >> 1);
                t2  <= t1;
            end
        end

    // stage 3: circular window and running sum
    always_ff @(posedge clk or negedge rst_n_i)
        if (!rst_n_i) begin
            {v3, t3} <= '0;
            sum <= '0;
            ptr <= '0;
            for (int k = 0; k < N; k++) win[k] <= '0;
        end else if (avg_clear) begin
            v3  <= 1'b0;
            sum <= '0;
            ptr <= '0;
            for (int k = 0; k < N; k++) win[k] <= '0;
        end else begin
            v3 <= v2;
            if (v2) begin
                sum      <= sum + S'(mag) - S'(win[ptr]);
                win[ptr] <= mag;
                ptr      <= ptr + 1'b1;
                t3       <= t2;
            end
        end

    // stage 4: registered average, held between pulses
    always_ff @(posedge clk or negedge rst_n_i)
        if (!rst_n_i) begin
            iq_rssi       <= '0;
            iq_rssi_valid <= 1'b0;
        end else begin
            iq_rssi_valid <= !avg_clear && v3 && t3;
            if (!avg_clear && v3 && t3) iq_rssi <= rssi_new;
        end

`ifdef IQ_RSSI_PEAK_HOLD_EN
    // peak of emitted averages since the last reset or clear
    always_ff @(posedge clk or negedge rst_n_i)
        if (!rst_n_i)                                        iq_rssi_peak <= '0;
        else if (avg_clear)                                  iq_rssi_peak <= '0;
        else if (v3 && t3 && (rssi_new > iq_rssi_peak))      iq_rssi_peak <= rssi_new;
`endif
endmodule

// File: tb/tb_iq_abs_avg.sv
// tb_iq_abs_avg: directed self-checking bench for iq_abs_avg
module tb_iq_abs_avg;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] ddc_i, ddc_q;
    logic        iq_valid, avg_clear;
    logic [15:0] iq_rssi;
    logic        iq_rssi_valid;
`ifdef IQ_RSSI_PEAK_HOLD_EN
    logic [15:0] iq_rssi_peak;
`endif

    int ncmp = 0, nerr = 0;
    int cyc = 0, npulse, first_cyc, last_cyc, min_gap, c16;
    logic [15:0] lrssi;

    iq_abs_avg #(.IQ_DATA_WIDTH(16), .WINDOW_LOG2(4)) dut (
        .clk(clk), .rstn(rstn), .ddc_i(ddc_i), .ddc_q(ddc_q),
        .iq_valid(iq_valid), .avg_clear(avg_clear),
`ifdef IQ_RSSI_PEAK_HOLD_EN
        .iq_rssi_peak(iq_rssi_peak),
`endif
        .iq_rssi(iq_rssi), .iq_rssi_valid(iq_rssi_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        npulse = 0; first_cyc = -1; last_cyc = -1; min_gap = 1000000; lrssi = 'x;
    endtask

    task automatic tick(input logic v, input logic [15:0] i, input logic [15:0] q, input logic c);
        iq_valid = v; ddc_i = i; ddc_q = q; avg_clear = c;
        @(posedge clk);
        #1;
        cyc++;
        if (iq_rssi_valid) begin
            if (npulse == 0) first_cyc = cyc;
            else if (cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
            npulse++;
            last_cyc = cyc;
            lrssi = iq_rssi;
        end
    endtask

    initial begin
        rstn = 1'b0; iq_valid = 0; avg_clear = 0; ddc_i = 0; ddc_q = 0;
        clr_stats();
        #12;
        chk("reset_rssi", iq_rssi, 0);
        chk("reset_valid", iq_rssi_valid, 0);
        rstn = 1'b1;
        repeat (3) tick(0, 0, 0, 0);

        // constant I=100 Q=-60 -> mag 80
        clr_stats();
        for (int n = 1; n <= 40; n++) begin
            tick(1, 16'd100, -16'sd60, 0);
            if (n == 16) c16 = cyc;
        end
        repeat (4) tick(0, 0, 0, 0);
        chk("a_first_lat", first_cyc, c16 + 3);
        chk("a_npulse", npulse, 4);
        chk("a_gap", min_gap, 8);
        chk("a_rssi", lrssi, 80);
`ifdef IQ_RSSI_PEAK_HOLD_EN
        chk("a_peak", iq_rssi_peak, 80);
`endif

        // eight zero-magnitude samples halve the window
        clr_stats();
        repeat (8) tick(1, 0, 0, 0);
        repeat (4) tick(0, 0, 0, 0);
        chk("b_npulse", npulse, 1);
        chk("b_rssi", lrssi, 40);
`ifdef IQ_RSSI_PEAK_HOLD_EN
        chk("b_peak_hold", iq_rssi_peak, 80);
`endif

        // clear holds iq_rssi; most-negative inputs saturate
        tick(0, 0, 0, 1);
        chk("c_clear_hold", iq_rssi, 40);
        chk("c_clear_valid", iq_rssi_valid, 0);
`ifdef IQ_RSSI_PEAK_HOLD_EN
        chk("c_peak_clr", iq_rssi_peak, 0);
`endif
        clr_stats();
        for (int n = 1; n <= 16; n++) begin
            tick(1, 16'h8000, 16'h8000, 0);
            if (n == 16) c16 = cyc;
        end
        repeat (4) tick(0, 0, 0, 0);
        chk("c_npulse", npulse, 1);
        chk("c_first_lat", first_cyc, c16 + 3);
        chk("c_rssi", lrssi, 32767);

        // one sample every third cycle, I=200 Q=0
        tick(0, 0, 0, 1);
        clr_stats();
        for (int n = 1; n <= 24; n++) begin
            tick(1, 16'd200, 0, 0);
            if (n == 16) c16 = cyc;
            tick(0, 16'd999, 16'd999, 0);
            tick(0, 16'd999, 16'd999, 0);
        end
        repeat (4) tick(0, 0, 0, 0);
        chk("d_npulse", npulse, 2);
        chk("d_first_lat", first_cyc, c16 + 3);
        chk("d_gap", min_gap, 24);
        chk("d_rssi", lrssi, 100);

        // clear coincident with the 10th sample drops it
        tick(0, 0, 0, 1);
        clr_stats();
        repeat (9) tick(1, 16'd50, 16'd50, 0);
        tick(1, 16'd50, 16'd50, 1);
        for (int n = 1; n <= 16; n++) begin
            if (n == 16) chk("e_no_early", npulse, 0);
            tick(1, 16'd50, 16'd50, 0);
            if (n == 16) c16 = cyc;
        end
        repeat (4) tick(0, 0, 0, 0);
        chk("e_npulse", npulse, 1);
        chk("e_first_lat", first_cyc, c16 + 3);
        chk("e_rssi", lrssi, 50);

        // asynchronous reset mid-window
        clr_stats();
        repeat (5) tick(1, 16'd100, -16'sd60, 0);
        #3 rstn = 1'b0;
        #1;
        chk("f_rst_rssi", iq_rssi, 0);
        chk("f_rst_valid", iq_rssi_valid, 0);
`ifdef IQ_RSSI_PEAK_HOLD_EN
        chk("f_rst_peak", iq_rssi_peak, 0);
`endif
        repeat (2) tick(1, 16'd100, -16'sd60, 0);
        rstn = 1'b1;
        repeat (3) tick(0, 0, 0, 0);
        repeat (15) tick(1, 16'd100, -16'sd60, 0);
        repeat (4) tick(0, 0, 0, 0);
        chk("f_no_early", npulse, 0);
        tick(1, 16'd100, -16'sd60, 0);
        c16 = cyc;
        repeat (4) tick(0, 0, 0, 0);
        chk("f_npulse", npulse, 1);
        chk("f_first_lat", first_cyc, c16 + 3);
        chk("f_rssi", lrssi, 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/iq_abs_avg.md
IQ_ABS_AVG -- requirements
Module: iq_abs_avg

Interface
REQ-001 SHALL have parameter IQ_DATA_WIDTH, default 16, I/Q sample and RSSI width.
REQ-002 SHALL have parameter WINDOW_LOG2, default 4, log2 of the averaging window length. The legal range is 2..6.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ddc_i  input  IQ_DATA_WIDTH  signed in-phase sample.
REQ-006 SHALL have port ddc_q  input  IQ_DATA_WIDTH  signed quadrature sample.
REQ-007 SHALL have port iq_valid  input  1  sample qualifier; a sample is accepted on every clk edge where it is high.
REQ-008 SHALL have port avg_clear  input  1  synchronous soft clear of the window and counters.
REQ-009 SHALL have port iq_rssi  output  IQ_DATA_WIDTH  signed, always non-negative windowed magnitude average.
REQ-010 SHALL have port iq_rssi_valid  output  1  one-cycle pulse qualifying iq_rssi.

Function
REQ-011 SHALL register per-sample absolute values in stage 1. -2^(IQ_DATA_WIDTH-1) saturates to 2^(IQ_DATA_WIDTH-1)-1.
REQ-012 SHALL form mag = (|I|+|Q|)>>1 in stage 2, unsigned, at most 2^(IQ_DATA_WIDTH-1)-1.
REQ-013 SHALL keep a circular buffer of the last 2^WINDOW_LOG2 mag values, with a write pointer that wraps from 2^WINDOW_LOG2-1 to 0.
REQ-014 SHALL update the running sum in stage 3 as sum <= sum + mag_new - mag_oldest. The sum is IQ_DATA_WIDTH-1+WINDOW_LOG2 bits unsigned and never overflows.
REQ-015 SHALL treat unfilled buffer entries as 0.
REQ-016 SHALL hold a fill counter that saturates at 2^WINDOW_LOG2 accepted samples. warm = counter saturated.
REQ-017 SHALL hold a 3-bit decimation counter that increments per accepted sample and wraps 7->0.
REQ-018 SHALL register iq_rssi = sum>>WINDOW_LOG2 in stage 4, and pulse iq_rssi_valid for exactly one cycle, when the sample that wrapped the decimation counter reaches stage 4 and warm is true.
REQ-019 SHALL have a latency of 3 clk cycles from the accepting edge of that sample to iq_rssi_valid high.
REQ-020 SHALL guarantee that consecutive iq_rssi_valid pulses are at least 8 clk cycles apart (downstream dB converter budget).
REQ-021 SHALL let bubbles (iq_valid low) advance no state; pipeline stages move only with their qualified data.
REQ-022 SHALL hold iq_rssi between pulses.
REQ-023 On avg_clear=1, SHALL zero the buffer contents, pointer, sum, fill and decimation counters, and pipeline valids at that edge. iq_rssi is held.
REQ-024 On avg_clear together with iq_valid, SHALL let the clear win and discard the sample.
REQ-025 SHALL not pulse iq_rssi_valid for any sample accepted before a clear.

Reset
REQ-026 On rstn=0, SHALL asynchronously force iq_rssi=0, iq_rssi_valid=0, sum=0, pointer=0, fill=0, decimation=0, all pipeline valids=0, and buffer=0.
REQ-027 Reset deasserted mid-window SHALL restart warm-up from zero; no output until 2^WINDOW_LOG2 new samples have been accepted.
REQ-028 SHALL synchronise reset release to clk before it is used internally.

Configuration
REQ-029 With macro IQ_RSSI_PEAK_HOLD_EN defined, SHALL add output port iq_rssi_peak  IQ_DATA_WIDTH. It holds the maximum iq_rssi emitted since the last reset/avg_clear, updates in the same cycle as iq_rssi_valid, and resets to 0.
REQ-030 Without IQ_RSSI_PEAK_HOLD_EN, SHALL omit the port and all peak logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: WINDOW_LOG2=4; I=100, Q=-60 on every cycle -> first iq_rssi_valid 3 cycles after the 16th sample, iq_rssi=80; then a pulse every 8 cycles with 80.
REQ-032 SHALL cover: I=-32768, Q=-32768 continuously -> iq_rssi=32767, with no wrap or sign error.
REQ-033 SHALL cover: iq_valid high every 3rd cycle, I=200, Q=0 -> pulses 24 cycles apart, iq_rssi=100; bubbles do not change sum.
REQ-034 SHALL cover: 16 samples of mag 80, then 8 samples of mag 0 -> the next pulse gives iq_rssi=40.
REQ-035 SHALL cover: avg_clear asserted with iq_valid at sample 10 -> that sample is dropped; the first pulse comes 3 cycles after the 16th post-clear sample.
REQ-036 SHALL cover: rstn dropped asynchronously mid-window -> outputs are 0 immediately; with IQ_RSSI_PEAK_HOLD_EN, iq_rssi_peak tracks 80 then holds 80 after a drop to 40.
